// File: rtl/fiber_link_pkg.sv
// Shared definitions for the crate fiber hit link (framer and mapping receivers).
// Provides word layout constants, link geometry, the framer state type and a
// helper that packs a stored {x-1, y-1} entry into a lane word.
package fiber_link_pkg;

    localparam logic [15:0] HDR_WORD = 16'hAAAA;

    localparam int unsigned NLANES  = 16;
    localparam int unsigned NSLOTS  = 16;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned TAG_W   = 10;
    localparam int unsigned COORD_W = 6;
    localparam int unsigned ENTRY_W = 2 * COORD_W;
    localparam int unsigned SLOT_W  = 4;
    localparam int unsigned COUNT_W = 9;

    localparam int unsigned C_BIT = 12;
    localparam int unsigned X_MSB = 11;
    localparam int unsigned X_LSB = 6;
    localparam int unsigned Y_MSB = 5;
    localparam int unsigned Y_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_TRL,
        ST_GAP
    } frame_state_t;

    // Entry is {x-1, y-1}; lane word carries the valid bit and zeros in [15:13].
    function automatic logic [WORD_W-1:0] lane_word(input logic [ENTRY_W-1:0] entry);
        logic [WORD_W-1:0] w;
        w              = '0;
        w[C_BIT]       = 1'b1;
        w[X_MSB:X_LSB] = entry[ENTRY_W-1:COORD_W];
        w[Y_MSB:Y_LSB] = entry[COORD_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/lane_slot_buf.sv
// Per-lane hit store: NSLOTS entries of {x-1, y-1}, written by slot index while
// hits are collected and read combinationally by slot index while framing.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
module lane_slot_buf
    import fiber_link_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [SLOT_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [SLOT_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [NSLOTS];

    // No reset: entries are only ever read when qualified by the hit count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fiber_hit_framer.sv
// Transmit-side framer for the crate fiber hit link. Buffers up to 256 legal
// (x,y) hits, then on trig sends header, 16 payload cycles and a tagged trailer.
// Ports: clk, rst (sync, active-high); hit_valid/hit_ready/hit_x/hit_y hit input;
// trig/trig_tag frame start; busy, hit_count, err_coord, err_trig status;
// fiber framing word and fxch00..fxch15 lane words (all registered).
// The output registers follow the state register by one cycle, so the last
// GAP output cycle overlaps the first IDLE state cycle.
module fiber_hit_framer
    import fiber_link_pkg::*;
#(
    parameter int unsigned MAX_COORD  = 37,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hit_valid,
    output logic                hit_ready,
    input  logic [COORD_W-1:0]  hit_x,
    input  logic [COORD_W-1:0]  hit_y,
    input  logic                trig,
    input  logic [TAG_W-1:0]    trig_tag,
    output logic                busy,
    output logic [COUNT_W-1:0]  hit_count,
    output logic                err_coord,
    output logic                err_trig,
    output logic [WORD_W-1:0]   fiber,
    output logic [WORD_W-1:0]   fxch00,
    output logic [WORD_W-1:0]   fxch01,
    output logic [WORD_W-1:0]   fxch02,
    output logic [WORD_W-1:0]   fxch03,
    output logic [WORD_W-1:0]   fxch04,
    output logic [WORD_W-1:0]   fxch05,
    output logic [WORD_W-1:0]   fxch06,
    output logic [WORD_W-1:0]   fxch07,
    output logic [WORD_W-1:0]   fxch08,
    output logic [WORD_W-1:0]   fxch09,
    output logic [WORD_W-1:0]   fxch10,
    output logic [WORD_W-1:0]   fxch11,
    output logic [WORD_W-1:0]   fxch12,
    output logic [WORD_W-1:0]   fxch13,
    output logic [WORD_W-1:0]   fxch14,
    output logic [WORD_W-1:0]   fxch15
);

    frame_state_t       state;
    logic [SLOT_W-1:0]  slot;
    logic [7:0]         gap_cnt;
    logic [TAG_W-1:0]   tag_q;
    logic [WORD_W-1:0]  lane_q  [NLANES];
    logic [ENTRY_W-1:0] rd_data [NLANES];

    logic               hit_fire;
    logic               hit_legal;
    logic               hit_store;
    logic [ENTRY_W-1:0] hit_entry;

    // Count of 256 (bit 8 set) means the buffer is full.
    assign hit_ready = !rst && (state == ST_IDLE) && !hit_count[COUNT_W-1];
    assign busy      = (state != ST_IDLE);

    assign hit_fire  = hit_valid && hit_ready;
    assign hit_legal = (hit_x != '0) && (hit_x <= COORD_W'(MAX_COORD)) &&
                       (hit_y != '0) && (hit_y <= COORD_W'(MAX_COORD));
    assign hit_store = hit_fire && hit_legal;
    assign hit_entry = {COORD_W'(hit_x - 6'd1), COORD_W'(hit_y - 6'd1)};

    // One store per lane: lane = count[3:0], slot = count[7:4]; read slot tracks payload cycle.
    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        lane_slot_buf u_buf (
            .clk   (clk),
            .we    (hit_store && (hit_count[SLOT_W-1:0] == SLOT_W'(g))),
            .waddr (hit_count[2*SLOT_W-1:SLOT_W]),
            .wdata (hit_entry),
            .raddr (slot),
            .rdata (rd_data[g])
        );
    end

    // Frame sequencer, hit counter, sticky errors and registered link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            slot      <= '0;
            gap_cnt   <= '0;
            tag_q     <= '0;
            hit_count <= '0;
            err_coord <= 1'b0;
            err_trig  <= 1'b0;
            fiber     <= '0;
            for (int i = 0; i < NLANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            fiber <= '0;
            for (int i = 0; i < NLANES; i++) begin
                lane_q[i] <= '0;
            end

            if (hit_store) begin
                hit_count <= hit_count + 9'd1;
            end
            if (hit_fire && !hit_legal) begin
                err_coord <= 1'b1;
            end
            if (trig && (state != ST_IDLE)) begin
                err_trig <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        tag_q <= trig_tag;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    fiber <= HDR_WORD;
                    slot  <= '0;
                    state <= ST_PAY;
                end
                ST_PAY: begin
                    // Buffer index of lane i in this cycle is {slot, i}.
                    for (int i = 0; i < NLANES; i++) begin
                        if (COUNT_W'({slot, SLOT_W'(i)}) < hit_count) begin
                            lane_q[i] <= lane_word(rd_data[i]);
                        end
                    end
                    slot <= slot + 4'd1;
                    if (slot == SLOT_W'(NSLOTS - 1)) begin
                        hit_count <= '0;
                        state     <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    fiber <= WORD_W'(tag_q);
                    if (GAP_CYCLES > 1) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 2)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fxch00 = lane_q[0];
    assign fxch01 = lane_q[1];
    assign fxch02 = lane_q[2];
    assign fxch03 = lane_q[3];
    assign fxch04 = lane_q[4];
    assign fxch05 = lane_q[5];
    assign fxch06 = lane_q[6];
    assign fxch07 = lane_q[7];
    assign fxch08 = lane_q[8];
    assign fxch09 = lane_q[9];
    assign fxch10 = lane_q[10];
    assign fxch11 = lane_q[11];
    assign fxch12 = lane_q[12];
    assign fxch13 = lane_q[13];
    assign fxch14 = lane_q[14];
    assign fxch15 = lane_q[15];

endmodule

// File: tb/tb_fiber_hit_framer.sv
// Self-checking bench for fiber_hit_framer: table of single-hit frames plus
// hand-written sequences for multi-hit, full buffer, errors, back-to-back and reset.
module tb_fiber_hit_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit_valid;
    logic        hit_ready;
    logic [5:0]  hit_x;
    logic [5:0]  hit_y;
    logic        trig;
    logic [9:0]  trig_tag;
    logic        busy;
    logic [8:0]  hit_count;
    logic        err_coord;
    logic        err_trig;
    logic [15:0] fiber;
    logic [15:0] fx [16];

    always #5 clk = ~clk;

    fiber_hit_framer #(.MAX_COORD(37), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_x(hit_x), .hit_y(hit_y),
        .trig(trig), .trig_tag(trig_tag),
        .busy(busy), .hit_count(hit_count), .err_coord(err_coord), .err_trig(err_trig),
        .fiber(fiber),
        .fxch00(fx[0]),  .fxch01(fx[1]),  .fxch02(fx[2]),  .fxch03(fx[3]),
        .fxch04(fx[4]),  .fxch05(fx[5]),  .fxch06(fx[6]),  .fxch07(fx[7]),
        .fxch08(fx[8]),  .fxch09(fx[9]),  .fxch10(fx[10]), .fxch11(fx[11]),
        .fxch12(fx[12]), .fxch13(fx[13]), .fxch14(fx[14]), .fxch15(fx[15])
    );

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [9:0]  tag;
        logic [15:0] exp_l0;
        logic [15:0] exp_trl;
    } vec_t;

    int         ntests = 0;
    int         nfail  = 0;
    int         cyc    = 0;
    int         hdr_cyc = 0;
    bit [11:0]  mdl [$];
    logic       exp_ec = 1'b0;
    logic       exp_et = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_lane(input int k, input int i);
        int idx;
        idx = 16 * (k - 1) + i;
        if (idx < mdl.size()) return {4'b0001, mdl[idx]};
        return 16'h0000;
    endfunction

    task automatic send_hit(input logic [5:0] x, input logic [5:0] y);
        logic exp_rdy;
        logic legal;
        exp_rdy = (mdl.size() < 256);
        legal   = (x >= 6'd1) && (x <= 6'd37) && (y >= 6'd1) && (y <= 6'd37);
        hit_valid = 1'b1;
        hit_x = x;
        hit_y = y;
        chk("hit_ready", 16'(hit_ready), 16'(exp_rdy));
        if (exp_rdy) begin
            if (legal) mdl.push_back({6'(x - 6'd1), 6'(y - 6'd1)});
            else       exp_ec = 1'b1;
        end
        tick();
        hit_valid = 1'b0;
        chk("hit_count", 16'(hit_count), 16'(mdl.size()));
    endtask

    task automatic start_trig(input logic [9:0] tag);
        trig = 1'b1;
        trig_tag = tag;
        tick();
        trig = 1'b0;
        trig_tag = 10'h0;
    endtask

    // Entered with the DUT state already at HDR (trig sampled on the previous edge).
    task automatic check_frame(input logic [9:0] tag, input int stray_k, input int abort_k,
                               input bit chain, input logic [9:0] chain_tag,
                               output logic [15:0] cap_l0, output logic [15:0] cap_trl);
        cap_l0 = 16'h0;
        cap_trl = 16'h0;
        tick();
        trig = 1'b0;
        hdr_cyc = cyc;
        chk("hdr_fiber", fiber, 16'hAAAA);
        chk("hdr_busy", 16'(busy), 16'h1);
        for (int i = 0; i < 16; i++) chk($sformatf("hdr_lane%0d", i), fx[i], 16'h0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            trig = 1'b0;
            chk($sformatf("pay%0d_fiber", k), fiber, 16'h0);
            for (int i = 0; i < 16; i++)
                chk($sformatf("pay%0d_lane%0d", k, i), fx[i], exp_lane(k, i));
            if (k == 1) cap_l0 = fx[0];
            if (k == stray_k) begin
                trig = 1'b1;
                exp_et = 1'b1;
            end
            if (k == abort_k) begin
                rst = 1'b1;
                tick();
                chk("rst_fiber", fiber, 16'h0);
                for (int i = 0; i < 16; i++) chk($sformatf("rst_lane%0d", i), fx[i], 16'h0);
                chk("rst_hit_count", 16'(hit_count), 16'h0);
                chk("rst_busy", 16'(busy), 16'h0);
                chk("rst_hit_ready", 16'(hit_ready), 16'h0);
                chk("rst_err_coord", 16'(err_coord), 16'h0);
                chk("rst_err_trig", 16'(err_trig), 16'h0);
                rst = 1'b0;
                mdl.delete();
                exp_ec = 1'b0;
                exp_et = 1'b0;
                tick();
                chk("post_rst_hit_ready", 16'(hit_ready), 16'h1);
                return;
            end
        end
        tick();
        chk("trl_fiber", fiber, {6'b0, tag});
        for (int i = 0; i < 16; i++) chk($sformatf("trl_lane%0d", i), fx[i], 16'h0);
        chk("trl_hit_count", 16'(hit_count), 16'h0);
        cap_trl = fiber;
        mdl.delete();
        if (chain) begin
            trig = 1'b1;
            trig_tag = chain_tag;
        end
        tick();
        trig = 1'b0;
        trig_tag = 10'h0;
        chk("gap_fiber", fiber, 16'h0);
        for (int i = 0; i < 16; i++) chk($sformatf("gap_lane%0d", i), fx[i], 16'h0);
        chk("gap_busy", 16'(busy), 16'(chain));
        chk("err_coord", 16'(err_coord), 16'(exp_ec));
        chk("err_trig", 16'(err_trig), 16'(exp_et));
    endtask

    initial begin
        vec_t        vecs [5];
        logic [15:0] l0;
        logic [15:0] trl;
        int          h1;

        vecs[0] = '{x: 6'd5,  y: 6'd12, tag: 10'h155, exp_l0: 16'h110B, exp_trl: 16'h0155};
        vecs[1] = '{x: 6'd1,  y: 6'd1,  tag: 10'h3FF, exp_l0: 16'h1000, exp_trl: 16'h03FF};
        vecs[2] = '{x: 6'd37, y: 6'd37, tag: 10'h000, exp_l0: 16'h1924, exp_trl: 16'h0000};
        vecs[3] = '{x: 6'd37, y: 6'd1,  tag: 10'h2AA, exp_l0: 16'h1900, exp_trl: 16'h02AA};
        vecs[4] = '{x: 6'd20, y: 6'd3,  tag: 10'h001, exp_l0: 16'h14C2, exp_trl: 16'h0001};

        rst = 1'b1; hit_valid = 1'b0; hit_x = 6'd0; hit_y = 6'd0; trig = 1'b0; trig_tag = 10'h0;
        tick();
        tick();
        chk("reset_hit_ready", 16'(hit_ready), 16'h0);
        rst = 1'b0;
        chk("reset_fiber", fiber, 16'h0);
        chk("reset_lane0", fx[0], 16'h0);
        chk("reset_lane15", fx[15], 16'h0);
        chk("reset_hit_count", 16'(hit_count), 16'h0);
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_err_coord", 16'(err_coord), 16'h0);
        chk("reset_err_trig", 16'(err_trig), 16'h0);
        tick();

        // Single-hit frames from the table.
        for (int v = 0; v < 5; v++) begin
            send_hit(vecs[v].x, vecs[v].y);
            start_trig(vecs[v].tag);
            check_frame(vecs[v].tag, 0, 0, 1'b0, 10'h0, l0, trl);
            chk($sformatf("vec%0d_lane0", v), l0, vecs[v].exp_l0);
            chk($sformatf("vec%0d_trailer", v), trl, vecs[v].exp_trl);
        end

        // Hit accepted in the same cycle as trig is framed.
        hit_valid = 1'b1; hit_x = 6'd3; hit_y = 6'd4;
        trig = 1'b1; trig_tag = 10'h0C3;
        mdl.push_back({6'd2, 6'd3});
        tick();
        hit_valid = 1'b0; trig = 1'b0; trig_tag = 10'h0;
        check_frame(10'h0C3, 0, 0, 1'b0, 10'h0, l0, trl);
        chk("same_cycle_lane0", l0, 16'h1083);

        // 17 hits spill into PAY2 lane 0.
        for (int x = 1; x <= 17; x++) send_hit(6'(x), 6'd11);
        chk("h17_count", 16'(hit_count), 16'd17);
        start_trig(10'h017);
        check_frame(10'h017, 0, 0, 1'b0, 10'h0, l0, trl);
        chk("h17_count_after", 16'(hit_count), 16'h0);

        // Illegal coordinates are consumed and flagged.
        send_hit(6'd0, 6'd5);
        send_hit(6'd5, 6'd38);
        chk("err_coord_set", 16'(err_coord), 16'h1);
        send_hit(6'd2, 6'd2);
        chk("illegal_count", 16'(hit_count), 16'h1);
        start_trig(10'h0F0);
        check_frame(10'h0F0, 0, 0, 1'b0, 10'h0, l0, trl);
        chk("illegal_lane0", l0, 16'h1041);

        // Back-to-back: trig in the first IDLE cycle, headers 19 cycles apart.
        send_hit(6'd9, 6'd9);
        start_trig(10'h111);
        check_frame(10'h111, 0, 0, 1'b1, 10'h222, l0, trl);
        h1 = hdr_cyc;
        check_frame(10'h222, 0, 0, 1'b0, 10'h0, l0, trl);
        chk("b2b_spacing", 16'(hdr_cyc - h1), 16'd19);
        chk("b2b_trailer", trl, 16'h0222);
        chk("b2b_err_trig", 16'(err_trig), 16'h0);

        // trig during PAY5 is ignored and flagged.
        send_hit(6'd4, 6'd4);
        start_trig(10'h033);
        check_frame(10'h033, 5, 0, 1'b0, 10'h0, l0, trl);
        chk("stray_err_trig", 16'(err_trig), 16'h1);
        chk("stray_lane0", l0, 16'h10C3);

        // Fill to 256, then hold valid against a full buffer.
        for (int n = 0; n < 256; n++) send_hit(6'(n % 37 + 1), 6'(n / 37 + 1));
        hit_valid = 1'b1; hit_x = 6'd1; hit_y = 6'd1;
        chk("full_ready0", 16'(hit_ready), 16'h0);
        tick();
        chk("full_ready1", 16'(hit_ready), 16'h0);
        chk("full_count", 16'(hit_count), 16'd256);
        hit_valid = 1'b0;
        start_trig(10'h2F0);
        check_frame(10'h2F0, 0, 0, 1'b0, 10'h0, l0, trl);
        chk("full_ready_idle", 16'(hit_ready), 16'h1);

        // Reset in PAY8 aborts; the next frame is empty.
        send_hit(6'd7, 6'd8);
        send_hit(6'd10, 6'd30);
        send_hit(6'd37, 6'd2);
        start_trig(10'h3C3);
        check_frame(10'h3C3, 0, 8, 1'b0, 10'h0, l0, trl);
        start_trig(10'h0AB);
        check_frame(10'h0AB, 0, 0, 1'b0, 10'h0, l0, trl);
        chk("empty_lane0", l0, 16'h0);
        chk("empty_trailer", trl, 16'h00AB);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
